// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the Hamming (16,11) SECDED encoder/decoder pair.
// Contains the decoder FSM state enum, the status flag encodings, the
// default memory layout constants and the bit positions of the parity
// and data bits inside an encoded 16-bit word.
//
// Encoded word layout, bit 15..0:
//   {d11..d5, p8, d4..d2, p4, d1, p2, p1, p0}
// Bit k (1..15) is Hamming position k; bit 0 is overall parity.
package hamming_pkg;

  localparam int DEF_NUM_WORDS = 15;
  localparam int DEF_SRC_BASE  = 30;
  localparam int DEF_DST_BASE  = 0;
  localparam int DEF_ADDR_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_SEC = 2'b01;
  localparam logic [1:0] FLAG_DED = 2'b10;

  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  // Data bits sit on the non-power-of-two positions: d1 at 3, d2..d4 at
  // 5..7 and d5..d11 at 9..15, so the payload is a simple concatenation.
  localparam int D1_POS     = 3;
  localparam int D2_LO_POS  = 5;
  localparam int D4_HI_POS  = 7;
  localparam int D5_LO_POS  = 9;
  localparam int D11_HI_POS = 15;

  function automatic logic [10:0] extract_data(input logic [15:0] w);
    return {w[D11_HI_POS:D5_LO_POS], w[D4_HI_POS:D2_LO_POS], w[D1_POS]};
  endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// hamming_secded_core
// Purely combinational SECDED decode of one 16-bit Hamming word.
//
// Ports:
//   word  in  16  encoded word (layout in hamming_pkg)
//   data  out 11  corrected payload d11..d1 (bit 0 = d1)
//   flag  out 2   FLAG_OK / FLAG_SEC / FLAG_DED
module hamming_secded_core
  import hamming_pkg::*;
(
  input  logic [15:0] word,
  output logic [10:0] data,
  output logic [1:0]  flag
);

  logic [3:0]  syndrome;
  logic        parity;
  logic [15:0] fixed;

  // The syndrome is the XOR of the positions of all set bits; for a clean
  // codeword it is zero, for a single error it names the flipped position.
  // Odd overall parity means an odd number of flips (assumed one); even
  // parity with a nonzero syndrome means two flips, which cannot be fixed.
  // A single error with zero syndrome is p0 itself, so data is untouched.
  always_comb begin
    syndrome = 4'd0;
    for (int k = 1; k < 16; k++) begin
      if (word[k]) syndrome = syndrome ^ 4'(k);
    end
    parity = ^word;
    fixed  = word;
    flag   = FLAG_OK;
    if (parity) begin
      flag = FLAG_SEC;
      if (syndrome != 4'd0) fixed[syndrome] = ~word[syndrome];
    end else if (syndrome != 4'd0) begin
      flag = FLAG_DED;
    end
    data = extract_data(fixed);
  end

endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
// Reads NUM_WORDS encoded 16-bit words from a shared byte-wide memory,
// decodes each with SECDED and writes back {flag, 3'b000, d11..d9} and
// d8..d1 as a byte pair. Five cycles per word; the memory is registered,
// so read data arrives the cycle after the address is presented.
//
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous active-low reset
//   req        in   1       start pulse, sampled only in IDLE/DONE
//   done       out  1       high while finished, held until next req
//   mem_addr   out  ADDR_W  byte address for read or write
//   mem_wen    out  1       write enable
//   mem_wdata  out  8       write byte
//   mem_rdata  in   8       read byte (valid one cycle after mem_addr)
//   n_single   out  4       saturating count of corrected words (*)
//   n_double   out  4       saturating count of double-error words (*)
//
// (*) Only present when the macro HAMMING_DEC_STATS_EN is defined.
module hamming_secded_decoder
  import hamming_pkg::*;
#(
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int SRC_BASE  = DEF_SRC_BASE,
  parameter int DST_BASE  = DEF_DST_BASE,
  parameter int ADDR_W    = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
`ifdef HAMMING_DEC_STATS_EN
  ,
  output logic [3:0]        n_single,
  output logic [3:0]        n_double
`endif
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_WORDS - 1);

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  lo_byte;
  logic [7:0]  hi_byte;
  logic [15:0] dec_word;
  logic [10:0] dec_data;
  logic [1:0]  dec_flag;
  logic [7:0]  out_lo;
  logic [7:0]  out_hi;

  // Byte address of word i within a region: base + 2i (+1 for the high byte).
  function automatic logic [ADDR_W-1:0] word_addr(input int base, input logic [3:0] i,
                                                  input logic hi);
    return ADDR_W'(base) + ADDR_W'({i, hi});
  endfunction

  // Outputs are registered on entry to each state, so the low output byte
  // must be ready on the CAP edge while the high byte is still on
  // mem_rdata; bypass the latch for that one cycle.
  assign dec_word = (state == CAP) ? {mem_rdata, lo_byte} : {hi_byte, lo_byte};

  hamming_secded_core u_core (
    .word (dec_word),
    .data (dec_data),
    .flag (dec_flag)
  );

  assign out_lo = dec_data[7:0];
  assign out_hi = {dec_flag, 3'b000, dec_data[10:8]};

  // Main sequencer. Every memory-port output is set on the edge that enters
  // the state in which it must be visible. done rises one cycle after DONE
  // is entered and drops on the same edge that accepts a new req.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= 4'd0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wdata <= 8'h00;
      lo_byte   <= 8'h00;
      hi_byte   <= 8'h00;
`ifdef HAMMING_DEC_STATS_EN
      n_single  <= 4'd0;
      n_double  <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (req) begin
            state    <= RD_LO;
            idx      <= 4'd0;
            done     <= 1'b0;
            mem_addr <= word_addr(SRC_BASE, 4'd0, 1'b0);
`ifdef HAMMING_DEC_STATS_EN
            n_single <= 4'd0;
            n_double <= 4'd0;
`endif
          end else if (state == DONE) begin
            done <= 1'b1;
          end
        end
        RD_LO: begin
          state    <= RD_HI;
          mem_addr <= word_addr(SRC_BASE, idx, 1'b1);
        end
        RD_HI: begin
          state   <= CAP;
          lo_byte <= mem_rdata;
        end
        CAP: begin
          state     <= WR_LO;
          hi_byte   <= mem_rdata;
          mem_wen   <= 1'b1;
          mem_addr  <= word_addr(DST_BASE, idx, 1'b0);
          mem_wdata <= out_lo;
        end
        WR_LO: begin
          state     <= WR_HI;
          mem_addr  <= word_addr(DST_BASE, idx, 1'b1);
          mem_wdata <= out_hi;
        end
        WR_HI: begin
          mem_wen <= 1'b0;
`ifdef HAMMING_DEC_STATS_EN
          if (dec_flag == FLAG_SEC && n_single != 4'hF) n_single <= n_single + 4'd1;
          if (dec_flag == FLAG_DED && n_double != 4'hF) n_double <= n_double + 4'd1;
`endif
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            state    <= RD_LO;
            idx      <= idx + 4'd1;
            mem_addr <= word_addr(SRC_BASE, idx + 4'd1, 1'b0);
          end
        end
        default: begin
          state   <= IDLE;
          mem_wen <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// tb_hamming_secded_decoder
// Self-checking bench for hamming_secded_decoder. A registered byte memory
// model sits on the DUT port; expected write transactions are queued when
// a pass is set up and popped as the DUT writes. Define
// HAMMING_DEC_STATS_EN to also exercise the error counters.
module tb_hamming_secded_decoder;
  import hamming_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_wen;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
`ifdef HAMMING_DEC_STATS_EN
  logic [3:0] n_single;
  logic [3:0] n_double;
`endif

  logic [7:0] mem [256];
  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;

  wr_t         exp_q[$];
  logic [15:0] words[15];
  logic [7:0]  exp_lo[15];
  logic [7:0]  exp_hi[15];
  int          exp_single;
  int          exp_double;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  hamming_secded_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef HAMMING_DEC_STATS_EN
    ,
    .n_single  (n_single),
    .n_double  (n_double)
`endif
  );

  // Registered single-port memory with a bench-side backdoor write port.
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    if (mem_wen) mem[mem_addr] = mem_wdata;
    if (bd_we) mem[bd_addr] = bd_data;
  end

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    int dpos[11];
    logic p;
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    w = 16'h0000;
    for (int j = 0; j < 11; j++) w[dpos[j]] = d[j];
    for (int b = 0; b < 4; b++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) if ((k & (1 << b)) != 0) p = p ^ w[k];
      w[1 << b] = p;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] payload(input logic [15:0] w);
    logic [10:0] d;
    int dpos[11];
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    for (int j = 0; j < 11; j++) d[j] = w[dpos[j]];
    return d;
  endfunction

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // Writes source words into memory and fills the destination with 8'hAA.
  task automatic load_words();
    for (int i = 0; i < 15; i++) begin
      bd_write(8'(30 + 2 * i), words[i][7:0]);
      bd_write(8'(31 + 2 * i), words[i][15:8]);
      bd_write(8'(2 * i), 8'hAA);
      bd_write(8'(2 * i + 1), 8'hAA);
    end
    @(negedge clk);
  endtask

  task automatic push_expected();
    exp_q.delete();
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back('{addr: 8'(2 * i), data: exp_lo[i]});
      exp_q.push_back('{addr: 8'(2 * i + 1), data: exp_hi[i]});
    end
  endtask

  // Issues req, checks every DUT write against the scoreboard and returns
  // the number of cycles from the req-sampling edge to done. A single req
  // pulse is injected when the cycle count equals pulse_at.
  task automatic applyStimulus(input int pulse_at, output int lat);
    wr_t e;
    bit finished;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    finished = 1'b0;
    n_checks++;
    if (done !== 1'b0) $display("[TB] FAIL accept_done: done=%b expected 0", done);
    else n_pass++;
    while (!finished && lat < 200) begin
      @(negedge clk);
      req = (lat == pulse_at);
      if (done === 1'b1) begin
        finished = 1'b1;
      end else if (mem_wen === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL extra_write: addr=%h data=%h expected no write", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data)
            $display("[TB] FAIL write: addr=%h data=%h expected addr=%h data=%h",
                     mem_addr, mem_wdata, e.addr, e.data);
          else n_pass++;
        end
      end
      if (!finished) begin
        @(posedge clk);
        lat++;
      end
    end
    req = 1'b0;
    n_checks++;
    if (!finished) $display("[TB] FAIL done_timeout: waited %0d cycles expected done", lat);
    else n_pass++;
    n_checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL missing_writes: %0d left expected 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req = 1'b0;
    bd_we = 1'b0;
    bd_addr = 8'h00;
    bd_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done, mem_wen, mem_addr, mem_wdata} !== 18'h0)
      $display("[TB] FAIL reset_outputs: done=%b wen=%b addr=%h wdata=%h expected all 0",
               done, mem_wen, mem_addr, mem_wdata);
    else n_pass++;
    n_checks++;
    if (dut.state !== IDLE) $display("[TB] FAIL reset_state: state=%0d expected IDLE", dut.state);
    else n_pass++;
`ifdef HAMMING_DEC_STATS_EN
    n_checks++;
    if (n_single !== 4'd0 || n_double !== 4'd0)
      $display("[TB] FAIL reset_stats: single=%0d double=%0d expected 0 0", n_single, n_double);
    else n_pass++;
`endif
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int lat, input int exp_lat);
    n_checks++;
    if (lat !== exp_lat) $display("[TB] FAIL %s_latency: %0d cycles expected %0d", name, lat, exp_lat);
    else n_pass++;
`ifdef HAMMING_DEC_STATS_EN
    n_checks++;
    if (n_single !== 4'(exp_single) || n_double !== 4'(exp_double))
      $display("[TB] FAIL %s_stats: single=%0d double=%0d expected %0d %0d",
               name, n_single, n_double, exp_single, exp_double);
    else n_pass++;
`endif
  endtask

  task automatic test_all_zero();
    int lat;
    for (int i = 0; i < 15; i++) begin
      words[i] = 16'h0000;
      exp_lo[i] = 8'h00;
      exp_hi[i] = 8'h00;
    end
    exp_single = 0;
    exp_double = 0;
    load_words();
    push_expected();
    applyStimulus(-1, lat);
    checkOutput("all_zero", lat, 76);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) $display("[TB] FAIL done_held: done=%b expected 1", done);
    else n_pass++;
  endtask

  task automatic test_patterns();
    int lat;
    logic [15:0] pw[5];
    logic [7:0]  pl[5];
    logic [7:0]  ph[5];
    pw = '{16'hFFFF, 16'hFFFE, 16'h0020, 16'h0028, 16'h0000};
    pl = '{8'hFF, 8'hFF, 8'h00, 8'h03, 8'h00};
    ph = '{8'h07, 8'h47, 8'h40, 8'h80, 8'h00};
    for (int i = 0; i < 15; i++) begin
      words[i] = (i < 5) ? pw[i] : 16'h0000;
      exp_lo[i] = (i < 5) ? pl[i] : 8'h00;
      exp_hi[i] = (i < 5) ? ph[i] : 8'h00;
    end
    exp_single = 2;
    exp_double = 1;
    load_words();
    push_expected();
    applyStimulus(-1, lat);
    checkOutput("patterns", lat, 76);
  endtask

  task automatic test_random();
    int lat;
    int p1;
    int p2;
    logic [10:0] d;
    logic [15:0] w;
    exp_single = 0;
    exp_double = 0;
    for (int i = 0; i < 15; i++) begin
      d = 11'($urandom_range(0, 2047));
      w = encode(d);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + $urandom_range(1, 15)) % 16;
      if (i % 3 == 0) begin
        exp_lo[i] = d[7:0];
        exp_hi[i] = {FLAG_OK, 3'b000, d[10:8]};
      end else if (i % 3 == 1) begin
        w[p1] = ~w[p1];
        exp_lo[i] = d[7:0];
        exp_hi[i] = {FLAG_SEC, 3'b000, d[10:8]};
        exp_single++;
      end else begin
        w[p1] = ~w[p1];
        w[p2] = ~w[p2];
        d = payload(w);
        exp_lo[i] = d[7:0];
        exp_hi[i] = {FLAG_DED, 3'b000, d[10:8]};
        exp_double++;
      end
      words[i] = w;
    end
    load_words();
    push_expected();
    applyStimulus(-1, lat);
    checkOutput("random", lat, 76);
  endtask

  // Reuses the random word set left by test_random.
  task automatic test_reset_mid_pass();
    int lat;
    int cyc;
    load_words();
    exp_q.delete();
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!(mem_wen === 1'b1 && mem_addr === 8'd14) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) $display("[TB] FAIL wr_lo7_timeout: waited %0d cycles expected WR_LO", cyc);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_wen !== 1'b0 || dut.state !== IDLE)
      $display("[TB] FAIL mid_reset: wen=%b state=%0d expected 0 IDLE", mem_wen, dut.state);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (mem[13] !== exp_hi[6] || mem[14] !== 8'hAA)
      $display("[TB] FAIL partial_writes: mem13=%h mem14=%h expected %h AA", mem[13], mem[14], exp_hi[6]);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    push_expected();
    applyStimulus(-1, lat);
    checkOutput("after_reset", lat, 76);
  endtask

  task automatic test_back_to_back();
    int lat;
    push_expected();
    applyStimulus(20, lat);
    checkOutput("ignored_req", lat, 76);
    repeat (2) @(negedge clk);
    n_checks++;
    if (done !== 1'b1) $display("[TB] FAIL done_before_restart: done=%b expected 1", done);
    else n_pass++;
    push_expected();
    applyStimulus(-1, lat);
    checkOutput("second_pass", lat, 76);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_patterns();
    test_random();
    test_reset_mid_pass();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
